// File: rtl/rpsc_alarm_reporter.sv
// rpsc_alarm_reporter: reporting end of one RPSC card's alarm latches.
// Registers the card's latched-alarm vector and drives the panel lamps from it.
// Sends the alarm state as a serial frame whenever the state changes, when an
// acknowledge asks for it, and on a periodic idle refresh. Also turns the
// operator acknowledge into a single-cycle latch-clear strobe.
//
// Frame on o_tx, LSB first within each field:
//   START(0) | CARD_ID[7:0] | snapshot[N_ALARMS-1:0] | PARITY | STOP(1)
// PARITY makes the total number of ones in CARD_ID, snapshot and PARITY even.
// Every bit lasts CLKS_PER_BIT cycles. o_busy is high for the whole frame.
//
// Interface protocol: there is no valid/ready handshake. o_clear_pulse is a
// fire-and-forget strobe that lasts one cycle. o_busy only reports status.
module rpsc_alarm_reporter #(
  parameter int         N_ALARMS       = 8,
  parameter logic [7:0] CARD_ID        = 8'd8,
  parameter int         CLKS_PER_BIT   = 16,
  parameter int         REFRESH_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_ALARMS-1:0] i_alarm_la,
  input  logic                i_clear_req,
  input  logic                i_lamptest,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_clear_pulse,
  output logic [N_ALARMS-1:0] o_lamp,
  output logic [2:0]          dbg_state
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int FW = N_ALARMS + 9;  // CARD_ID + snapshot + parity

  localparam logic [BW-1:0] BAUD_LAST    = BW'(CLKS_PER_BIT - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [3:0]    ID_LAST      = 4'd7;
  localparam logic [3:0]    DATA_LAST    = 4'(N_ALARMS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ID     = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t              state;
  logic [N_ALARMS-1:0] alarm_q;
  logic                clr_q;
  logic                clr_prev;
  logic                clear_pulse;
  logic [N_ALARMS-1:0] last_sent;
  logic                pending;
  logic [RW-1:0]       refresh_cnt;
  logic [BW-1:0]       baud_cnt;
  logic [3:0]          bit_cnt;
  logic [FW-1:0]       frame_sr;  // {parity, snapshot, CARD_ID}, shifted out LSB first
  logic                tx;

  logic clr_rise;
  logic bit_done;
  logic start_frame;

  assign clr_rise    = clr_q & ~clr_prev;
  assign bit_done    = (baud_cnt == BAUD_LAST);
  assign start_frame = (alarm_q != last_sent) || pending || (refresh_cnt == REFRESH_LAST);

  assign o_tx          = tx;
  assign o_busy        = (state != S_IDLE);
  assign o_clear_pulse = clear_pulse;
  assign o_lamp        = i_lamptest ? {N_ALARMS{1'b1}} : alarm_q;
  assign dbg_state     = state;

  // Input register and acknowledge edge detector. The strobe works even while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_q     <= '0;
      clr_q       <= 1'b0;
      clr_prev    <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      alarm_q     <= i_alarm_la;
      clr_q       <= i_clear_req;
      clr_prev    <= clr_q;
      clear_pulse <= clr_rise;
    end
  end

  // Frame FSM: trigger decision, bit timing, serial shifter and resend bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      last_sent   <= '0;
      pending     <= 1'b0;
      refresh_cnt <= '0;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      frame_sr    <= '0;
      tx          <= 1'b1;
    end else begin
      if (state != S_IDLE) begin
        baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start_frame) begin
            state       <= S_START;
            tx          <= 1'b0;
            frame_sr    <= {^{CARD_ID, alarm_q}, alarm_q, CARD_ID};
            last_sent   <= alarm_q;
            pending     <= 1'b0;
            refresh_cnt <= '0;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
          end else if (refresh_cnt != REFRESH_LAST) begin
            refresh_cnt <= refresh_cnt + 1'b1;
          end
        end
        S_START: begin
          if (bit_done) begin
            state    <= S_ID;
            tx       <= frame_sr[0];
            frame_sr <= frame_sr >> 1;
            bit_cnt  <= '0;
          end
        end
        S_ID: begin
          if (bit_done) begin
            tx       <= frame_sr[0];
            frame_sr <= frame_sr >> 1;
            if (bit_cnt == ID_LAST) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (bit_done) begin
            tx       <= frame_sr[0];
            frame_sr <= frame_sr >> 1;
            if (bit_cnt == DATA_LAST) begin
              state   <= S_PARITY;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase

      // An acknowledge edge wins over the clear on frame entry. That way the
      // cleared state always gets its own frame after the current one.
      if (clr_rise) begin
        pending <= 1'b1;
      end else if ((state != S_IDLE) && (alarm_q != last_sent)) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rpsc_alarm_reporter.sv
// Bench for rpsc_alarm_reporter with small bit time and refresh period.
// The stimulus pushes each hand-computed frame payload {parity, data, id}.
// A frame monitor decodes o_tx at mid-bit and pops and compares each frame.
module tb_rpsc_alarm_reporter;

  localparam int CPB       = 4;
  localparam int REFRESH   = 200;
  localparam int NBITS     = 19;            // 8 + 11
  localparam int FRAME_CYC = NBITS * CPB;   // 76
  localparam int W         = 17;            // parity + data + id

  logic       clk;
  logic       rst_n;
  logic [7:0] alarm_la;
  logic       clear_req;
  logic       lamptest;
  logic       tx;
  logic       busy;
  logic       clear_pulse;
  logic [7:0] lamp;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int frames_done = 0;
  int frames_started = 0;
  int last_gap = 0;
  int pulse_cnt = 0;

  rpsc_alarm_reporter #(
    .N_ALARMS(8),
    .CARD_ID(8'd8),
    .CLKS_PER_BIT(CPB),
    .REFRESH_CYCLES(REFRESH)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .i_alarm_la(alarm_la),
    .i_clear_req(clear_req),
    .i_lamptest(lamptest),
    .o_tx(tx),
    .o_busy(busy),
    .o_clear_pulse(clear_pulse),
    .o_lamp(lamp),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic expect_frame(input logic [7:0] data, input logic par);
    exp_q.push_back({par, data, 8'h08});
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int i;
    i = 0;
    while (frames_done < target && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("frame_wait", frames_done, target);
  endtask

  // scoreboard monitor: decode frames at mid-bit, pop and compare
  initial begin : frame_monitor
    logic [NBITS-1:0] bits;
    logic [W-1:0]     exp;
    int  gap;
    bit  aborted;
    bit  busy_ok;
    logic busy_end;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        gap = 0;
      end else if (busy === 1'b1 && tx === 1'b0) begin
        frames_started++;
        last_gap = gap + 1;
        gap = 0;
        aborted = 1'b0;
        busy_ok = 1'b1;
        busy_end = 1'b1;
        bits = '0;
        for (int j = 1; j <= FRAME_CYC; j++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (j < FRAME_CYC) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if ((j % CPB) == CPB / 2) bits = {tx, bits[NBITS-1:1]};
          end else begin
            busy_end = busy;
          end
        end
        if (!aborted) begin
          frames_done++;
          check("start_bit", {31'd0, bits[0]}, 32'd0);
          check("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
          check("busy_len", {30'd0, busy_ok, busy_end}, 32'd2);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got payload 0x%0h expected no frame", bits[NBITS-2:1]);
          end else begin
            exp = exp_q.pop_front();
            check("payload", {15'd0, bits[NBITS-2:1]}, {15'd0, exp});
          end
        end
      end else if (busy === 1'b0) begin
        gap++;
      end
    end
  end

  // clear-pulse counter; also checks that each pulse lasts one cycle
  initial begin : pulse_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (clear_pulse === 1'b1) begin
        pulse_cnt++;
        check("pulse_width", {31'd0, prev}, 32'd0);
      end
      prev = clear_pulse;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int base;
    int p0;
    rst_n     = 1'b0;
    alarm_la  = 8'h00;
    clear_req = 1'b0;
    lamptest  = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulse", {31'd0, clear_pulse}, 32'd0);
    check("rst_lamp", {24'd0, lamp}, 32'd0);

    // refresh only: first frame after 199 idle cycles, data 0x00, parity 1
    expect_frame(8'h00, 1'b1);
    rst_n = 1'b1;
    wait_start(300, n);
    check("refresh_delay", n, REFRESH);
    wait_frames(1, 200);

    // 0x00 -> 0x05: tx low two edges after the change
    @(negedge clk);
    alarm_la = 8'h05;
    expect_frame(8'h05, 1'b1);
    @(posedge clk); #1;
    check("lat_edge1_tx", {31'd0, tx}, 32'd1);
    check("lamp_follow", {24'd0, lamp}, 32'h05);
    @(posedge clk); #1;
    check("lat_edge2_tx", {31'd0, tx}, 32'd0);
    wait_frames(2, 200);

    // change in flight: 0x01 frame keeps snapshot, 0x03 follows after one idle cycle
    @(negedge clk);
    alarm_la = 8'h01;
    expect_frame(8'h01, 1'b0);
    wait_start(10, n);
    repeat (20) @(posedge clk);
    @(negedge clk);
    alarm_la = 8'h03;
    expect_frame(8'h03, 1'b1);
    wait_frames(4, 400);
    check("gap_one_idle", last_gap, 1);

    // acknowledge held 50 cycles during a frame: one pulse, one follow-up frame
    @(negedge clk);
    alarm_la = 8'h07;
    expect_frame(8'h07, 1'b0);
    wait_start(10, n);
    @(negedge clk);
    p0 = pulse_cnt;
    clear_req = 1'b1;
    expect_frame(8'h07, 1'b0);
    @(posedge clk); #1;
    check("clr_edge1", {31'd0, clear_pulse}, 32'd0);
    @(posedge clk); #1;
    check("clr_edge2", {31'd0, clear_pulse}, 32'd1);
    @(posedge clk); #1;
    check("clr_edge3", {31'd0, clear_pulse}, 32'd0);
    repeat (47) @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    wait_frames(6, 400);
    check("clr_pulses", pulse_cnt - p0, 1);

    // lamp test: lamps forced on at once, frame data unaffected
    @(negedge clk);
    alarm_la = 8'h10;
    lamptest = 1'b1;
    expect_frame(8'h10, 1'b0);
    #1;
    check("lamptest_on", {24'd0, lamp}, 32'hFF);
    wait_frames(7, 200);
    lamptest = 1'b0;
    #1;
    check("lamptest_off", {24'd0, lamp}, 32'h10);

    // reset at bit 5 of a frame; afterwards only the refresh frame appears
    @(negedge clk);
    alarm_la = 8'h3C;
    wait_start(10, n);
    repeat (5 * CPB - 1) @(posedge clk);
    #2;
    rst_n = 1'b0;
    alarm_la = 8'h00;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    base = frames_done;
    expect_frame(8'h00, 1'b1);
    rst_n = 1'b1;
    wait_start(300, n);
    check("post_rst_refresh", n, REFRESH);
    wait_frames(base + 1, 200);

    // final report
    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rpsc_alarm_reporter.md
# rpsc_alarm_reporter

Reporting end of the RPSC card alarm latches. Samples a card's latched-alarm (LA) vector, drives front-panel lamps (with lamp test), and transmits the alarm state to the control panel as a fixed-format serial frame on every change and on a periodic refresh. Converts operator acknowledge into a one-cycle latch-clear pulse back to the card. One instance per card, between the card's LA outputs and the panel link.

## Interface
- N_ALARMS, 8, width of the latched-alarm vector (1..16)
- CARD_ID, 8'd8, 8-bit card address sent in every frame
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2)
- REFRESH_CYCLES, 1_000_000, idle cycles before an unconditional resend (≥1)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; assertion clears all state immediately
- i_alarm_la  in  N_ALARMS  latched alarm bits from the card, 1 = alarm
- i_clear_req  in  1  operator acknowledge, level; rising edge acts
- i_lamptest  in  1  level; forces all lamps on
- o_tx  out  1  serial frame output, idle high
- o_busy  out  1  high while a frame is in progress
- o_clear_pulse  out  1  one-cycle latch-clear strobe to the card
- o_lamp  out  N_ALARMS  panel lamp drive

## Operation
- Input register: i_alarm_la and i_clear_req registered once (alarm_q, clr_q); all decisions use the registered values.
- o_lamp = i_lamptest ? all ones : alarm_q. Lamp test never affects frame contents.
- Frame, LSB first within each field: START (0), CARD_ID[7:0], snapshot[N_ALARMS-1:0], PARITY (even parity over CARD_ID and snapshot, so total ones in those fields plus parity is even), STOP (1). Length = N_ALARMS + 11 bits.
- FSM: IDLE, START, ID, DATA, PARITY, STOP. Bit counter indexes ID/DATA; baud counter counts 0..CLKS_PER_BIT-1, state/bit advances when it reaches CLKS_PER_BIT-1.
- IDLE → START when any trigger holds: alarm_q ≠ last_sent, pending flag set, or refresh counter reached REFRESH_CYCLES-1. On entry, snapshot ← alarm_q, last_sent ← alarm_q, pending ← 0, refresh counter ← 0.
- STOP → IDLE after its full bit time. Retriggering from IDLE is allowed the cycle after STOP ends (at least one idle cycle between frames).
- alarm_q changing during a frame sets pending; the frame in flight keeps its snapshot.
- Refresh counter increments only in IDLE, saturating at REFRESH_CYCLES-1.
- Clear: rising edge of clr_q (clr_q=1, previous=0) → o_clear_pulse high exactly one cycle, whether or not busy; also sets pending so the cleared state is reported. Holding i_clear_req high issues no further pulses.
- o_busy = (state ≠ IDLE).

## Timing
- Reset values: o_tx=1, o_busy=0, o_clear_pulse=0, o_lamp=0, state IDLE, last_sent=0, pending=0, all counters 0.
- Input-change to o_tx falling: i_alarm_la change at edge k → alarm_q at k+1 → START entered and o_tx=0 at edge k+2.
- Each bit holds exactly CLKS_PER_BIT cycles; full frame (N_ALARMS+11)·CLKS_PER_BIT cycles with o_busy high throughout.
- i_clear_req rise at edge k → o_clear_pulse high during cycle after edge k+2 (detect on registered value), low after one cycle.
- Lamp output: one cycle from i_alarm_la (through alarm_q); i_lamptest is combinational to o_lamp.
- Simultaneous change + refresh expiry: one frame only. Simultaneous clear edge + frame start: pulse issued, pending set, second frame follows.
- Reset mid-frame: o_tx returns to 1 and o_busy to 0 asynchronously; no partial frame resumes after release.

## Test plan
- Reset release, i_alarm_la=0, REFRESH_CYCLES=200 → o_tx stays 1 for 199 idle cycles, then frame with ID=0x08, data 0x00, parity 1.
- i_alarm_la 0x00→0x05 (CLKS_PER_BIT=4) → o_tx low 2 cycles after change; bits ID 00010000 LSB-first, data 10100000, parity 1, stop 1; o_busy high 76 cycles.
- i_alarm_la 0x01→0x03 mid-frame → current frame carries 0x01, next frame carries 0x03 after one idle cycle.
- i_clear_req held high 50 cycles during a frame → exactly one o_clear_pulse, one follow-up frame after current ends.
- i_lamptest=1 with alarm 0x10 → o_lamp=0xFF immediately; frame data still 0x10.
- reset asserted at bit 5 of a frame → o_tx=1, o_busy=0 same cycle; after release, unchanged 0x00 input sends no frame until refresh.
